// File: rtl/div_if.sv
// Handshake and operand bundle between the EX-stage control and the multi-cycle divider.
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  start_i;
  logic                  signed_i;
  logic [DATA_W-1:0]     opa_i;
  logic [DATA_W-1:0]     opb_i;
  logic                  annul_i;
  logic                  hold_i;
  logic                  stall_o;
  logic                  ready_o;
  logic [2*DATA_W-1:0]   result_o;

  modport master (
    output start_i, signed_i, opa_i, opb_i, annul_i, hold_i,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i, annul_i, hold_i,
    output stall_o, ready_o, result_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU for EX: restoring shift-subtract on magnitudes, sign fix-up on completion.
// Build option: define DIV_RADIX4_EN to retire two quotient bits per DIV cycle.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
`ifdef DIV_RADIX4_EN
  localparam int ITERS = DATA_W / 2;
`else
  localparam int ITERS = DATA_W;
`endif
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, DIV, FINISH} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   rem_reg, rem_next;
  logic [DATA_W-1:0]   dvd_reg, dvd_next;
  logic [DATA_W-1:0]   dsr_reg, dsr_next;
  logic                neg_q_reg, neg_q_next;
  logic                neg_r_reg, neg_r_next;
  logic [2*DATA_W-1:0] result_reg, result_next;

  logic                accept;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W-1:0]   rem_step, dvd_step;
  logic [DATA_W-1:0]   q_fix, r_fix;

  assign accept = bus.start_i & ~bus.annul_i;
  assign a_mag  = (bus.signed_i & bus.opa_i[DATA_W-1]) ? -bus.opa_i : bus.opa_i;
  assign b_mag  = (bus.signed_i & bus.opb_i[DATA_W-1]) ? -bus.opb_i : bus.opb_i;

`ifdef DIV_RADIX4_EN
  logic [DATA_W+1:0] d3_reg;
  logic [DATA_W+1:0] trial;
  logic [1:0]        qbits;

  // 3x divisor is formed once on accept so each iteration only compares.
  always_ff @(posedge clk) begin
    if (rst)
      d3_reg <= '0;
    else if (state_reg == IDLE && accept)
      d3_reg <= {2'b00, b_mag} + {1'b0, b_mag, 1'b0};
  end

  always_comb begin
    trial = {rem_reg, dvd_reg[DATA_W-1:DATA_W-2]};
    if (trial >= d3_reg) begin
      rem_step = trial[DATA_W-1:0] - d3_reg[DATA_W-1:0];
      qbits    = 2'd3;
    end else if (trial >= {1'b0, dsr_reg, 1'b0}) begin
      rem_step = trial[DATA_W-1:0] - {dsr_reg[DATA_W-2:0], 1'b0};
      qbits    = 2'd2;
    end else if (trial >= {2'b00, dsr_reg}) begin
      rem_step = trial[DATA_W-1:0] - dsr_reg;
      qbits    = 2'd1;
    end else begin
      rem_step = trial[DATA_W-1:0];
      qbits    = 2'd0;
    end
    dvd_step = {dvd_reg[DATA_W-3:0], qbits};
  end
`else
  logic [DATA_W:0] trial;
  logic            qbit;

  always_comb begin
    trial    = {rem_reg, dvd_reg[DATA_W-1]};
    qbit     = (trial >= {1'b0, dsr_reg});
    // The difference is always below the divisor, so DATA_W bits hold it exactly.
    rem_step = qbit ? (trial[DATA_W-1:0] - dsr_reg) : trial[DATA_W-1:0];
    dvd_step = {dvd_reg[DATA_W-2:0], qbit};
  end
`endif

  assign q_fix = neg_q_reg ? -dvd_step : dvd_step;
  assign r_fix = neg_r_reg ? -rem_step : rem_step;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rem_next    = rem_reg;
    dvd_next    = dvd_reg;
    dsr_next    = dsr_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    result_next = result_reg;
    if (bus.annul_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start_i) begin
            rem_next   = '0;
            dvd_next   = a_mag;
            dsr_next   = b_mag;
            cnt_next   = '0;
            neg_q_next = bus.signed_i & (bus.opa_i[DATA_W-1] ^ bus.opb_i[DATA_W-1]);
            neg_r_next = bus.signed_i & bus.opa_i[DATA_W-1];
            if (bus.opb_i == '0) begin
              result_next = {bus.opa_i, {DATA_W{1'b1}}};
              state_next  = FINISH;
            end else begin
              state_next  = DIV;
            end
          end
        end
        DIV: begin
          rem_next = rem_step;
          dvd_next = dvd_step;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            result_next = {r_fix, q_fix};
            state_next  = FINISH;
          end
        end
        FINISH: begin
          if (!bus.hold_i)
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rem_reg    <= '0;
      dvd_reg    <= '0;
      dsr_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rem_reg    <= rem_next;
      dvd_reg    <= dvd_next;
      dsr_reg    <= dsr_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      result_reg <= result_next;
    end
  end

  // Low in FINISH so the instruction can leave EX on the release edge.
  assign bus.stall_o  = accept & (state_reg == IDLE || state_reg == DIV);
  assign bus.ready_o  = (state_reg == FINISH);
  assign bus.result_o = result_reg;
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divider for the EX stage of the MIPS core. Executes DIV and DIVU.
- Its `stall_o` output is the EX-stage divider stall that the hazard unit ORs into its longest-stall term.
- While busy, it holds EX/MEM/WB and the front end. It returns {HI, LO} = {remainder, quotient} for the HI/LO write path.
- Algorithm: restoring shift-subtract on operand magnitudes, with sign fix-up applied on completion.

Parameters:
- DATA_W, 32, operand width; must be even; quotient and remainder are each DATA_W bits.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  EX instruction is DIV/DIVU; held high while that instruction sits in EX
- signed_i  in  1  1 = DIV (signed), 0 = DIVU
- opa_i  in  DATA_W  dividend (rs), sampled on accept
- opb_i  in  DATA_W  divisor (rt), sampled on accept
- annul_i  in  1  kill the in-flight operation (driven by exception flush of EX)
- hold_i  in  1  EX held by other stall sources (instruction/data memory stall)
- stall_o  out  1  divider stall request to hazard unit
- ready_o  out  1  result_o valid
- result_o  out  2*DATA_W  {remainder, quotient}

Behaviour:
- Reset: state=IDLE, stall_o=0, ready_o=0, result_o=0, counter=0, internal registers=0.
- States: IDLE, DIV, FINISH.
- IDLE:
  - If start_i & ~annul_i, accept: latch magnitudes |opa|, |opb| (abs only when signed_i), latch the sign flags, clear the partial remainder.
  - If opb_i==0, go to FINISH with quotient=all ones and remainder=opa_i unchanged. This is deterministic for an architecturally undefined case.
  - Otherwise go to DIV with counter=0.
- DIV:
  - Each cycle performs one iteration: shift {rem, dividend} left 1; if rem >= divisor, subtract and set the quotient bit.
  - After iteration DATA_W-1, go to FINISH and register the sign-corrected result:
    - quotient negated when signed_i and sign(opa) != sign(opb);
    - remainder negated when signed_i and opa negative.
  - -2^31 / -1 yields quotient 0x80000000, remainder 0; no trap.
- FINISH:
  - ready_o=1; result_o held stable.
  - Return to IDLE on the first cycle where hold_i=0; the instruction leaves EX on that edge.
  - While hold_i=1, stay in FINISH and do not restart even though start_i is still high.
- stall_o (combinational):
  - = start_i & ~annul_i & (state==IDLE | state==DIV).
  - Low in FINISH, so EX can advance. Asserts in the same cycle start_i first rises.
- Latency (normal case): stall_o high for 1 + DATA_W cycles (33 at default); ready_o high from cycle 34 after start_i rises.
- Latency (divide by zero): stall_o high for 1 cycle.
- Back-to-back DIVs:
  - FINISH→IDLE on an advance edge.
  - The next DIV entering EX sees IDLE and is accepted in that cycle, with no bubble beyond its own stall.
- annul_i: highest priority after rst. Any state → IDLE at the next edge; ready_o=0; no result produced. An annul during an accept cycle suppresses the accept.
- rst mid-operation: same as annul, plus result_o cleared.
- result_o is only updated on entry to FINISH; outside FINISH it holds its last value and must be qualified by ready_o.
- Operands are sampled only on accept; changes on opa_i/opb_i afterwards are ignored.

Optional Feature:
- Macro: DIV_RADIX4_EN.
- Defined:
  - Two quotient bits per DIV cycle: compare against divisor, 2x and 3x divisor, with the 3x value precomputed on accept.
  - DIV lasts DATA_W/2 cycles; stall_o high 17 cycles at default.
  - Results are bit-identical to the radix-2 build.
- Undefined: radix-2, DATA_W DIV cycles.

Test Plan:
- DIVU 100/7, hold_i=0 → stall_o high exactly 33 cycles; then ready_o=1, result_o={0x00000002, 0x0000000E}.
- DIV -7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- DIVU 0x1234 / 0 → stall_o high 1 cycle; result_o={0x00001234, 0xFFFFFFFF}.
- Completion with hold_i=1 for 5 cycles after FINISH → ready_o and result_o stable all 5 cycles, no re-accept. Then hold_i=0 → IDLE next edge; an immediate second DIVU 9/3 gives {0, 3} after 33 stall cycles.
- annul_i pulsed at DIV cycle 10 → IDLE next edge, stall_o=0, ready_o never asserts. A following DIVU 50/5 completes correctly with {0, 10}.
- 10,000 random signed/unsigned operand pairs, with random annul_i and hold_i, compared against a reference model. Repeat with DIV_RADIX4_EN defined, expecting a stall length of 17.
